regfile_wb_arbiter: RTL

- Sole writer of the integer register file; drives its single write port (rd address, data, write enable).
- Merges two writeback sources:
  - the in-order pipeline WB stage, which has priority;
  - the multi-cycle mul/div unit, through a valid/ready handshake and a small result FIFO.
- Keeps a per-register pending scoreboard so decode can stall on hazards against outstanding mul/div results.
- Starvation guard holds the pipeline so queued mul/div results cannot wait forever.

---
 rtl/regfile_wb_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the integer register file.
// Merges the in-order pipeline WB stage with the mul/div result stream.
// Mul/div results are queued in a small FIFO, with a same-cycle bypass
// when the FIFO is empty. A per-register pending scoreboard tracks
// mul/div ops in flight. A starvation counter stalls the pipeline so that
// queued results are eventually written.
module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_wb_valid,
    input  logic [4:0]      pipe_wb_rd,
    input  logic [XLEN-1:0] pipe_wb_data,
    output logic            pipe_hold,
    input  logic            md_valid,
    input  logic [4:0]      md_rd,
    input  logic [XLEN-1:0] md_data,
    output logic            md_ready,
    input  logic            md_issue,
    input  logic [4:0]      md_issue_rd,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    input  logic [4:0]      chk_rd,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rd_busy,
    output logic            rf_we,
    output logic [4:0]      rf_rd_addr,
    output logic [XLEN-1:0] rf_wdata
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

    // FIFO storage; the head is read combinationally so a granted entry
    // reaches the register file write port in the same cycle.
    logic [4:0]      rd_mem   [FIFO_DEPTH];
    logic [XLEN-1:0] data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [STV_W-1:0] starve_reg, starve_next;
    logic [31:0]      pending_reg, pending_next;

    logic            fifo_empty;
    logic            fifo_full;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;
    logic            grant_pipe;
    logic            grant_fifo;
    logic            grant_bypass;
    logic            push;
    logic            pop;
    logic            retire;
    logic [4:0]      retire_rd;
    logic            issue_set;
    logic [4:0]      wr_rd;
    logic [XLEN-1:0] wr_data;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == DEPTH_C);
    assign head_rd    = rd_mem[rd_ptr_reg];
    assign head_data  = data_mem[rd_ptr_reg];

    // Grant selection: a starved FIFO head beats the pipeline, the
    // pipeline beats the FIFO otherwise, and bypass only on an empty FIFO.
    always_comb begin
        pipe_hold    = 1'b0;
        grant_pipe   = 1'b0;
        grant_fifo   = 1'b0;
        grant_bypass = 1'b0;
        if (rst_n) begin
            pipe_hold = (starve_reg == LIMIT_C) && !fifo_empty;
            if (pipe_hold) begin
                grant_fifo = 1'b1;
            end else if (pipe_wb_valid && (pipe_wb_rd != 5'd0)) begin
                grant_pipe = 1'b1;
            end else if (!fifo_empty) begin
                grant_fifo = 1'b1;
            end else if (md_valid) begin
                grant_bypass = 1'b1;
            end
        end
    end

    // A full FIFO still accepts a new result in a cycle where its head
    // is popped, so push and pop can overlap at full occupancy.
    assign md_ready = rst_n && (!fifo_full || grant_fifo || grant_bypass);
    assign push     = md_valid && md_ready && !grant_bypass;
    assign pop      = grant_fifo;

    assign retire    = grant_fifo || grant_bypass;
    assign retire_rd = grant_fifo ? head_rd : md_rd;
    assign issue_set = md_issue && (md_issue_rd != 5'd0);

    // Register file write port mux; writes to x0 are suppressed.
    always_comb begin
        wr_rd   = 5'd0;
        wr_data = '0;
        if (grant_pipe) begin
            wr_rd   = pipe_wb_rd;
            wr_data = pipe_wb_data;
        end else if (grant_fifo) begin
            wr_rd   = head_rd;
            wr_data = head_data;
        end else if (grant_bypass) begin
            wr_rd   = md_rd;
            wr_data = md_data;
        end
        rf_we      = (grant_pipe || grant_fifo || grant_bypass) && (wr_rd != 5'd0);
        rf_rd_addr = wr_rd;
        rf_wdata   = wr_data;
    end

    // FIFO pointer/occupancy and starvation counter next-state.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        starve_next = starve_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
        if (fifo_empty || pop) begin
            starve_next = '0;
        end else if (starve_reg != LIMIT_C) begin
            starve_next = starve_reg + STV_W'(1);
        end
    end

    // Scoreboard next-state per register; a same-cycle set beats a clear
    // and x0 never becomes pending.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pending_next[gi] = 1'b0;
            end else begin : g_bit
                assign pending_next[gi] = (issue_set && (md_issue_rd == 5'(gi))) ||
                                          (pending_reg[gi] && !(retire && (retire_rd == 5'(gi))));
            end
        end
    endgenerate

    assign rs1_busy = rst_n && pending_reg[chk_rs1];
    assign rs2_busy = rst_n && pending_reg[chk_rs2];
    assign rd_busy  = rst_n && pending_reg[chk_rd];

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            starve_reg  <= '0;
            pending_reg <= '0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            starve_reg  <= starve_next;
            pending_reg <= pending_next;
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates use.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_reg]   <= md_rd;
            data_mem[wr_ptr_reg] <= md_data;
        end
    end

endmodule
